// File: rtl/serial_xor_cipher_pkg.sv
// cipher_pkg: shared types and helpers for the multi-slot serial XOR cipher.
// Holds the controller state encoding, default sizes and the key rotation helper.
package cipher_pkg;

  localparam int DEF_MSG_SIZE = 64;
  localparam int DEF_KEY_SIZE = 8;
  localparam int DEF_NUM_KEYS = 4;

  // Widest key the rotation helper accepts; narrower keys occupy the low bits.
  localparam int MAX_KEY_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_MSG,
    ENCRYPT,
    SHIFT_OUT
  } state_t;

  // Rotate the low 'width' bits of value left by 'amount'; bits above 'width' come back as zero.
  function automatic logic [MAX_KEY_W-1:0] rotl(input logic [MAX_KEY_W-1:0] value,
                                                input int width,
                                                input int amount);
    logic [MAX_KEY_W-1:0] result;
    int src;
    result = '0;
    src    = 0;
    for (int i = 0; i < MAX_KEY_W; i++) begin
      if (i < width) begin
        src       = (i - (amount % width) + width) % width;
        result[i] = value[src];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_xor_cipher_if.sv
// serial_xor_cipher_if: serial pin bundle between the pad side (master) and the cipher (slave).
interface serial_xor_cipher_if
  import cipher_pkg::*;
#(
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int SEL_W    = $clog2(NUM_KEYS)
);

  logic                iData_in;
  logic                iKey_flag;
  logic                iMsg_flag;
  logic [SEL_W-1:0]    iKey_sel;
  logic                oData_out;
  logic                oData_flag;
  logic                oBusy;
  logic                oDone;
  logic                oErr;
  logic [NUM_KEYS-1:0] oKey_valid;

  modport master (
    output iData_in, iKey_flag, iMsg_flag, iKey_sel,
    input  oData_out, oData_flag, oBusy, oDone, oErr, oKey_valid
  );

  modport slave (
    input  iData_in, iKey_flag, iMsg_flag, iKey_sel,
    output oData_out, oData_flag, oBusy, oDone, oErr, oKey_valid
  );

endinterface

// File: rtl/serial_xor_cipher_shift_in.sv
// serial_shift_in: MSB-first deserialiser with bit counter, completion strobe and abort.
// 'value' already includes the bit being taken this cycle so a completed word can be stored on the same edge.
module serial_shift_in #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             take,
  input  logic             abort,
  input  logic             din,
  output logic [WIDTH-1:0] value,
  output logic             complete
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] count;

  assign value    = take ? {data[WIDTH-2:0], din} : data;
  assign complete = take && (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
    end else if (ena) begin
      if (abort) begin
        data  <= '0;
        count <= '0;
      end else if (take) begin
        data  <= value;
        count <= complete ? '0 : count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_xor_cipher.sv
// serial_xor_cipher: NUM_KEYS serially loaded key slots, one serial message, repeating-key XOR, serial output.
// Define ROLLING_KEY_EN to rotate the key left by the block index for each KEY_SIZE block.
module serial_xor_cipher
  import cipher_pkg::*;
#(
  parameter int MSG_SIZE = DEF_MSG_SIZE,
  parameter int KEY_SIZE = DEF_KEY_SIZE,
  parameter int NUM_KEYS = DEF_NUM_KEYS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  serial_xor_cipher_if.slave bus
);

  localparam int SEL_W   = $clog2(NUM_KEYS);
  localparam int NUM_BLK = MSG_SIZE / KEY_SIZE;
  localparam int OUT_W   = $clog2(MSG_SIZE) + 1;

  state_t              state, state_next;
  logic [KEY_SIZE-1:0] keys [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_valid;
  logic [SEL_W-1:0]    key_slot;
  logic [SEL_W-1:0]    enc_slot;
  logic                key_hold;
  logic                msg_hold;
  logic [MSG_SIZE-1:0] out_sreg;
  logic [MSG_SIZE-1:0] cipher;
  logic [KEY_SIZE-1:0] blk_key;
  logic [OUT_W-1:0]    out_cnt;
  logic                data_out;
  logic                data_flag;
  logic                done;
  logic                err;

  logic                key_start, msg_start;
  logic                key_take, msg_take;
  logic                key_abort, msg_abort;
  logic                key_complete, msg_complete;
  logic                sel_ok, out_last;
  logic [KEY_SIZE-1:0] key_word;
  logic [MSG_SIZE-1:0] msg_word;

  // A flag still high after a completed load must drop before it can start another one.
  assign key_start = bus.iKey_flag && !key_hold;
  assign msg_start = bus.iMsg_flag && !msg_hold && !bus.iKey_flag;

  assign key_take  = ((state == IDLE) && key_start) || ((state == LOAD_KEY) && bus.iKey_flag);
  assign key_abort = (state == LOAD_KEY) && !bus.iKey_flag;
  assign msg_take  = ((state == IDLE) && msg_start) || ((state == LOAD_MSG) && bus.iMsg_flag);
  assign msg_abort = (state == LOAD_MSG) && !bus.iMsg_flag;

  assign sel_ok   = (int'(bus.iKey_sel) < NUM_KEYS) && key_valid[bus.iKey_sel];
  assign out_last = (out_cnt == OUT_W'(MSG_SIZE));

  serial_shift_in #(.WIDTH(KEY_SIZE)) u_key_in (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .take     (key_take),
    .abort    (key_abort),
    .din      (bus.iData_in),
    .value    (key_word),
    .complete (key_complete)
  );

  serial_shift_in #(.WIDTH(MSG_SIZE)) u_msg_in (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .take     (msg_take),
    .abort    (msg_abort),
    .din      (bus.iData_in),
    .value    (msg_word),
    .complete (msg_complete)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (key_start) begin
          state_next = LOAD_KEY;
        end else if (msg_start) begin
          state_next = LOAD_MSG;
        end
      end
      LOAD_KEY: begin
        if (!bus.iKey_flag || key_complete) begin
          state_next = IDLE;
        end
      end
      LOAD_MSG: begin
        if (!bus.iMsg_flag) begin
          state_next = IDLE;
        end else if (msg_complete) begin
          state_next = sel_ok ? ENCRYPT : IDLE;
        end
      end
      ENCRYPT:   state_next = SHIFT_OUT;
      SHIFT_OUT: begin
        if (out_last) begin
          state_next = IDLE;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  // Block 0 is the most significant KEY_SIZE bits of the message.
  always_comb begin
    cipher  = '0;
    blk_key = '0;
    for (int j = 0; j < NUM_BLK; j++) begin
`ifdef ROLLING_KEY_EN
      blk_key = KEY_SIZE'(rotl(MAX_KEY_W'(keys[enc_slot]), KEY_SIZE, j % KEY_SIZE));
`else
      blk_key = keys[enc_slot];
`endif
      cipher[MSG_SIZE-1-j*KEY_SIZE -: KEY_SIZE] =
        msg_word[MSG_SIZE-1-j*KEY_SIZE -: KEY_SIZE] ^ blk_key;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        keys[i] <= '0;
      end
      key_valid <= '0;
      key_slot  <= '0;
      enc_slot  <= '0;
      key_hold  <= 1'b0;
      msg_hold  <= 1'b0;
      out_sreg  <= '0;
      out_cnt   <= '0;
      data_out  <= 1'b0;
      data_flag <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      err  <= 1'b0;

      if (!bus.iKey_flag) begin
        key_hold <= 1'b0;
      end else if ((state == LOAD_KEY) && key_complete) begin
        key_hold <= 1'b1;
      end

      if (!bus.iMsg_flag) begin
        msg_hold <= 1'b0;
      end else if ((state == LOAD_MSG) && msg_complete) begin
        msg_hold <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (key_start) begin
            key_slot                <= bus.iKey_sel;
            key_valid[bus.iKey_sel] <= 1'b0;
          end
        end
        LOAD_KEY: begin
          if (bus.iKey_flag && key_complete) begin
            keys[key_slot]      <= key_word;
            key_valid[key_slot] <= 1'b1;
          end
        end
        LOAD_MSG: begin
          if (bus.iMsg_flag && msg_complete) begin
            enc_slot <= bus.iKey_sel;
            err      <= !sel_ok;
          end
        end
        ENCRYPT: begin
          out_sreg <= cipher;
          out_cnt  <= '0;
        end
        SHIFT_OUT: begin
          if (out_last) begin
            data_out  <= 1'b0;
            data_flag <= 1'b0;
            done      <= 1'b1;
          end else begin
            data_out  <= out_sreg[MSG_SIZE-1];
            data_flag <= 1'b1;
            out_sreg  <= out_sreg << 1;
            out_cnt   <= out_cnt + OUT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.oData_out  = data_out;
  assign bus.oData_flag = data_flag;
  assign bus.oBusy      = (state == ENCRYPT) || (state == SHIFT_OUT);
  assign bus.oDone      = done;
  assign bus.oErr       = err;
  assign bus.oKey_valid = key_valid;

endmodule

// File: doc/serial_xor_cipher.md
Name: serial_xor_cipher

Overview:
Parametrised successor to the single-key bit-serial XOR datapath. It holds NUM_KEYS key slots that are loaded serially, and deserialises one MSG_SIZE-bit message. The message is encrypted with a repeating-key XOR under the selected slot, optionally with per-block key rotation. The result is shifted out serially with a data-valid flag. It sits between the chip's serial pins and the capture/monitor logic, replacing the separate deserializer, XOR and serializer chain.

Parameters:
MSG_SIZE, 64, message/ciphertext width in bits; must be an integer multiple of KEY_SIZE.
KEY_SIZE, 8, key width in bits; one XOR block is KEY_SIZE bits.
NUM_KEYS, 4, number of key slots; must be ≥2. SEL_W = $clog2(NUM_KEYS).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
ena  in  1  global enable; low = all state (FSM, counters, registers) holds
iData_in  in  1  shared serial input, MSB first
iKey_flag  in  1  high = shift iData_in into key slot iKey_sel, one bit per cycle
iMsg_flag  in  1  high = shift iData_in into message register, one bit per cycle
iKey_sel  in  SEL_W  slot to load (LOAD_KEY) or to encrypt with (sampled at message completion)
oData_out  out  1  serial ciphertext, MSB first
oData_flag  out  1  high while oData_out carries a valid ciphertext bit
oBusy  out  1  high in ENCRYPT and SHIFT_OUT
oDone  out  1  one-cycle pulse after the last ciphertext bit
oErr  out  1  one-cycle pulse when a message completes against an invalid slot
oKey_valid  out  NUM_KEYS  per-slot valid bits

Behaviour:
- Reset values: all outputs 0, FSM IDLE, counters 0, key slots and message 0, oKey_valid all 0.
- FSM states: IDLE, LOAD_KEY, LOAD_MSG, ENCRYPT, SHIFT_OUT.
- IDLE, iKey_flag=1 → LOAD_KEY:
  - Latch the slot index.
  - Clear oKey_valid[slot].
  - The first bit is sampled on this same edge.
- IDLE, iMsg_flag=1 (iKey_flag=0) → LOAD_MSG; the first bit is sampled on the same edge.
- Both flags high in IDLE: key load wins; the message flag is ignored.
- LOAD_KEY:
  - Shift left into the slot, one bit per cycle.
  - When the KEY_SIZE-th bit is taken, set oKey_valid[slot] and go to IDLE.
  - Flag dropping early: return to IDLE with the slot left invalid (partial key discarded).
  - Further bits while the flag stays high after completion are ignored until the flag drops (re-arm requires flag low for ≥1 cycle).
- LOAD_MSG:
  - Same rules, with counter width $clog2(MSG_SIZE)+1.
  - When the MSG_SIZE-th bit is taken, sample iKey_sel.
  - If the selected slot is valid → ENCRYPT.
  - Otherwise: pulse oErr, discard the message, go to IDLE.
  - Early flag drop → IDLE, message discarded, no pulse.
- ENCRYPT (one cycle):
  - Block j (j=0 is bits [MSG_SIZE-1 -: KEY_SIZE]) gives C_j = M_j ^ K_j.
  - K_j = slot key (see Optional Feature).
  - Load C into the output shift register.
- SHIFT_OUT: emit MSG_SIZE bits MSB first, oData_flag=1 throughout.
- Latency, with the last message bit sampled at edge N:
  - ENCRYPT occupies N..N+1.
  - oData_out/oData_flag valid for cycles N+2 .. N+1+MSG_SIZE.
  - oDone=1 for cycle N+2+MSG_SIZE, FSM back in IDLE.
- In ENCRYPT/SHIFT_OUT, iKey_flag and iMsg_flag are ignored; key slots cannot be modified mid-encryption.
- ena low mid-operation: everything freezes, outputs hold their values, and the operation resumes when ena returns.
- rst mid-operation: immediate return to reset values, including all key slots.

Optional Feature:
Macro ROLLING_KEY_EN.
- Defined: K_j = rotate-left(key, j mod KEY_SIZE); the rotation is computed combinationally in ENCRYPT.
- Undefined: K_j = key for every j (plain repeating key).
- Timing and handshake are identical in both builds.

Decomposition:
- Package cipher_pkg: FSM state enum; localparams for default MSG_SIZE/KEY_SIZE/NUM_KEYS; a rotl function parametrised on KEY_SIZE.
- One sub-module, serial_shift_in: parametrised width, MSB-first shift register with bit counter, complete pulse and flag-drop abort. It is instantiated once for the message; key slots share one instance plus a slot write-enable decode.

Test Plan:
1. Slot 0 loaded with 0xAC; message 64'h0123456789ABCDEF, iKey_sel=0 → oData_flag high 64 cycles starting 2 cycles after the last input bit, serial out 64'hAD8FE9CB25076143, then oDone pulse; oKey_valid=4'b0001.
2. ROLLING_KEY_EN build, same stimulus → block0=0xAD, block1=0x23^0x59=0x7A, block7=0xEF^rotl(0xAC,7)=0xEF^0x56=0xB9.
3. Key flag dropped after 5 bits into slot 2 → oKey_valid[2]=0; then a full message with iKey_sel=2 → oErr pulse, no oData_flag, FSM IDLE.
4. Slot 1=0xFF, slot 3=0x0F; message all-zeros with iKey_sel=3 → ciphertext 64'h0F0F0F0F0F0F0F0F; iKey_flag/iMsg_flag toggled during SHIFT_OUT → no effect on slots or output.
5. ena held low for 10 cycles mid SHIFT_OUT → oData_out/oData_flag frozen, full correct ciphertext after resume, total flag-high cycles = 64.
6. rst asserted at output bit 30 → oData_flag=0, oKey_valid=0 in the same cycle (asynchronous); reload key/message after release → correct ciphertext.
